// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: T1..T6 one-hot ring plus control-word decode of the current T-state and opcode.
// Optional build macro SEQ_EARLY_RETIRE_EN: return to T1 right after an instruction's last non-idle T-state.
module control_sequencer (
    input  logic       clk,
    input  logic       nclr,
    input  logic [3:0] I_sequencer,
    input  logic       run,
    output logic       Cp,
    output logic       Ep,
    output logic       nLm,
    output logic       nCE,
    output logic       nLi,
    output logic       nEi,
    output logic       nLa,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       nLb,
    output logic       nLo,
    output logic       halt,
    output logic [5:0] T
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [5:0] t_reg;
    logic [5:0] t_next;
    logic       halt_reg;
    logic       halt_next;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic t_legal;
    logic retire;

    assign is_lda = (I_sequencer == OP_LDA);
    assign is_add = (I_sequencer == OP_ADD);
    assign is_sub = (I_sequencer == OP_SUB);
    assign is_out = (I_sequencer == OP_OUT);
    assign is_hlt = (I_sequencer == OP_HLT);

    // Exactly one bit set; anything else is an upset and restarts the ring at T1.
    assign t_legal = (t_reg != 6'd0) && ((t_reg & (t_reg - 6'd1)) == 6'd0);

`ifdef SEQ_EARLY_RETIRE_EN
    logic is_nop;
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    assign retire = t_reg[5]
                  | (t_reg[4] & is_lda)
                  | (t_reg[3] & is_out)
                  | (t_reg[2] & is_nop);
`else
    assign retire = t_reg[5];
`endif

    always_comb begin
        t_next    = t_reg;
        halt_next = halt_reg;
        if (halt_reg) begin
            t_next = 6'd0;
        end else if (!t_legal) begin
            t_next = T1;
        end else if (run) begin
            if (t_reg[3] && is_hlt) begin
                halt_next = 1'b1;
                t_next    = 6'd0;
            end else if (retire) begin
                t_next = T1;
            end else begin
                t_next = {t_reg[4:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            t_reg    <= T1;
            halt_reg <= 1'b0;
        end else begin
            t_reg    <= t_next;
            halt_reg <= halt_next;
        end
    end

    assign T    = t_reg;
    assign halt = halt_reg;

    // Strobes are purely combinational; nclr low forces them inactive irrespective of T.
    always_comb begin
        Cp  = 1'b0;
        Ep  = 1'b0;
        nLm = 1'b1;
        nCE = 1'b1;
        nLi = 1'b1;
        nEi = 1'b1;
        nLa = 1'b1;
        Ea  = 1'b0;
        Su  = 1'b0;
        Eu  = 1'b0;
        nLb = 1'b1;
        nLo = 1'b1;
        if (nclr && !halt_reg) begin
            case (t_reg)
                T1: begin
                    Ep  = 1'b1;
                    nLm = 1'b0;
                end
                T2: begin
                    Cp = 1'b1;
                end
                T3: begin
                    nCE = 1'b0;
                    nLi = 1'b0;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        nEi = 1'b0;
                        nLm = 1'b0;
                    end else if (is_out) begin
                        Ea  = 1'b1;
                        nLo = 1'b0;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        nCE = 1'b0;
                        nLa = 1'b0;
                    end else if (is_add || is_sub) begin
                        nCE = 1'b0;
                        nLb = 1'b0;
                        Su  = is_sub;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        Eu  = 1'b1;
                        nLa = 1'b0;
                        Su  = is_sub;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
